// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: load-use interlock, branch squash,
// and multdiv launch/wait sequencing with a watchdog and stall counter.
module pipeline_stall_controller #(
  parameter int CNT_W  = 32,
  parameter int MD_MAX = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_use_stall,
  input  logic             dx_is_md,
  input  logic             md_ready,
  input  logic             md_exception,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic             mw_bubble,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WC_W = (MD_MAX < 1) ? 1 : $clog2(MD_MAX + 1);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MD_START = 2'd1;
  localparam logic [1:0] MD_WAIT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       st;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Exception is consumed by the writeback path, not by sequencing.
  logic unused_md_exception;
  assign unused_md_exception = md_exception;

  always_comb begin
    st         = reset ? RUN : state_q;
    state_d    = st;
    wcnt_d     = wcnt_q;
    pc_en      = 1'b1;
    fd_en      = 1'b1;
    dx_en      = 1'b1;
    xm_en      = 1'b1;
    mw_en      = 1'b1;
    fd_flush   = 1'b0;
    dx_flush   = 1'b0;
    mw_bubble  = 1'b0;
    md_start   = 1'b0;
    md_timeout = 1'b0;
    md_busy    = (st == MD_START) || (st == MD_WAIT);
    case (st)
      RUN: begin
        if (dx_is_md) begin
          {pc_en, fd_en, dx_en, xm_en} = 4'b0000;
          mw_bubble = 1'b1;
          state_d   = MD_START;
          wcnt_d    = '0;
        end else if (branch_taken) begin
          fd_flush = 1'b1;
          dx_flush = 1'b1;
        end else if (load_use_stall) begin
          pc_en    = 1'b0;
          fd_en    = 1'b0;
          dx_flush = 1'b1;
        end
      end
      MD_START: begin
        {pc_en, fd_en, dx_en, xm_en} = 4'b0000;
        mw_bubble = 1'b1;
        md_start  = 1'b1;
        state_d   = MD_WAIT;
      end
      MD_WAIT: begin
        if (md_ready) begin
          state_d = RUN;
        end else if (wcnt_q == WC_W'(MD_MAX)) begin
          // Watchdog squashes the stuck md insn and resumes fetch.
          md_timeout = 1'b1;
          dx_flush   = 1'b1;
          state_d    = RUN;
        end else begin
          {pc_en, fd_en, dx_en, xm_en} = 4'b0000;
          mw_bubble = 1'b1;
          wcnt_d    = wcnt_q + WC_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
    cnt_d = cnt_q + CNT_W'(!reset && !pc_en);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed scoreboard bench for pipeline_stall_controller
// (MD_MAX=4, CNT_W=4 so watchdog and counter wrap are reachable).
module tb_pipeline_stall_controller;

  logic clock = 1'b0;
  logic reset, lu, md, rdy, exc, br;
  logic pc_en, fd_en, dx_en, xm_en, mw_en;
  logic fd_flush, dx_flush, mw_bubble;
  logic md_start, md_busy, md_timeout;
  logic [3:0] stall_count;

  always #5 clock = ~clock;

  pipeline_stall_controller #(.CNT_W(4), .MD_MAX(4)) dut (
    .clock(clock), .reset(reset),
    .load_use_stall(lu), .dx_is_md(md),
    .md_ready(rdy), .md_exception(exc),
    .branch_taken(br),
    .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en),
    .xm_en(xm_en), .mw_en(mw_en),
    .fd_flush(fd_flush), .dx_flush(dx_flush),
    .mw_bubble(mw_bubble), .md_start(md_start),
    .md_busy(md_busy), .md_timeout(md_timeout),
    .stall_count(stall_count)
  );

  // {pc,fd,dx,xm,mw, fdf,dxf,mwb, start,busy,tout}
  localparam logic [10:0] E_RUN = 11'b11111_000_000;
  localparam logic [10:0] E_BR  = 11'b11111_110_000;
  localparam logic [10:0] E_LU  = 11'b00111_010_000;
  localparam logic [10:0] E_MDR = 11'b00001_001_000;
  localparam logic [10:0] E_MDS = 11'b00001_001_110;
  localparam logic [10:0] E_MDW = 11'b00001_001_010;
  localparam logic [10:0] E_RDY = 11'b11111_000_010;
  localparam logic [10:0] E_TO  = 11'b11111_010_011;

  typedef struct {
    logic [10:0] o;
    logic [3:0]  c;
    string       tag;
  } exp_t;

  exp_t sb[$];
  logic [3:0] model_cnt = 4'd0;
  int pass_cnt = 0;
  int tot_cnt  = 0;

  wire [10:0] obs = {pc_en, fd_en, dx_en, xm_en, mw_en,
                     fd_flush, dx_flush, mw_bubble,
                     md_start, md_busy, md_timeout};

  task automatic step(input logic r, input logic l,
                      input logic m, input logic y,
                      input logic b, input logic [10:0] e,
                      input string tag);
    exp_t x;
    @(posedge clock);
    #1;
    reset = r; lu = l; md = m; rdy = y; exc = y; br = b;
    x.o = e; x.c = model_cnt; x.tag = tag;
    sb.push_back(x);
    if (r) model_cnt = 4'd0;
    else if (!e[10]) model_cnt = model_cnt + 4'd1;
    @(negedge clock);
    x = sb.pop_front();
    tot_cnt++;
    assert (obs === x.o) pass_cnt++;
    else $error("FAIL %s outputs obs=%b exp=%b", x.tag, obs, x.o);
    tot_cnt++;
    assert (stall_count === x.c) pass_cnt++;
    else $error("FAIL %s stall_count obs=%0d exp=%0d",
                x.tag, stall_count, x.c);
  endtask

  initial begin
    reset = 1'b1; lu = 0; md = 0; rdy = 0; exc = 0; br = 0;
    repeat (2) @(posedge clock);
    // reset state, and outputs follow inputs during reset
    step(1, 0, 0, 0, 0, E_RUN, "rst_idle");
    step(1, 1, 0, 0, 0, E_LU,  "rst_lu");
    step(0, 0, 0, 0, 0, E_RUN, "idle");
    // load-use bubble
    step(0, 1, 0, 0, 0, E_LU,  "lu");
    step(0, 0, 0, 1, 0, E_RUN, "lu_after_rdy_ign");
    // branch overrides load-use
    step(0, 1, 0, 0, 1, E_BR,  "br_lu");
    step(0, 0, 0, 0, 0, E_RUN, "br_after");
    // multdiv, ready on 5th wait cycle (ties with watchdog)
    step(0, 0, 1, 0, 0, E_MDR, "md_run");
    step(0, 0, 1, 1, 0, E_MDS, "md_start_rdy_ign");
    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 0, 0, E_MDW, "md_wait");
    step(0, 0, 1, 1, 0, E_RDY, "md_ready");
    step(0, 0, 0, 0, 0, E_RUN, "md_done");
    // watchdog
    step(0, 0, 1, 0, 0, E_MDR, "wd_run");
    step(0, 0, 1, 0, 0, E_MDS, "wd_start");
    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 0, 0, E_MDW, "wd_wait");
    step(0, 0, 1, 0, 0, E_TO,  "wd_timeout");
    step(0, 0, 0, 0, 0, E_RUN, "wd_after");
    // reset on 2nd wait cycle, stale ready afterward
    step(0, 0, 1, 0, 0, E_MDR, "rm_run");
    step(0, 0, 1, 0, 0, E_MDS, "rm_start");
    step(0, 0, 1, 0, 0, E_MDW, "rm_wait");
    step(1, 0, 0, 0, 0, E_RUN, "rm_reset");
    step(0, 0, 0, 1, 0, E_RUN, "rm_stale_rdy");
    step(0, 0, 0, 0, 0, E_RUN, "rm_idle");
    // back-to-back md
    step(0, 0, 1, 0, 0, E_MDR, "bb1_run");
    step(0, 0, 1, 0, 0, E_MDS, "bb1_start");
    step(0, 0, 1, 0, 0, E_MDW, "bb1_wait");
    step(0, 0, 1, 1, 0, E_RDY, "bb1_ready");
    step(0, 1, 1, 0, 0, E_MDR, "bb2_run");
    step(0, 0, 1, 0, 0, E_MDS, "bb2_start");
    step(0, 0, 1, 1, 0, E_RDY, "bb2_ready");
    step(0, 0, 0, 0, 0, E_RUN, "bb2_done");
    // stall counter wraps modulo 16
    for (int i = 0; i < 18; i++)
      step(0, 1, 0, 0, 0, E_LU, "wrap_lu");
    step(0, 0, 0, 0, 0, E_RUN, "wrap_end");
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
